// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle: decoded source/destination fields, forwarding data
// and the stall / forward-select results returned to the datapath.
interface hazard_scoreboard_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int TW = 2
);
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_use_rs;
  logic          d_use_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic          d_wr;
  logic [AW-1:0] d_rd;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          flush;
  logic [DW-1:0] grf_rs;
  logic [DW-1:0] grf_rt;
  logic [DW-1:0] e_res;
  logic [DW-1:0] m_res;
  logic [DW-1:0] w_res;
  logic          stall;
  logic [DW-1:0] d_rs_val;
  logic [DW-1:0] d_rt_val;
  logic [1:0]    e_rs_sel;
  logic [1:0]    e_rt_sel;
  logic          m_rt_sel;
  logic          md_busy;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wr, d_rd, d_tnew, d_md_start, d_md_div, d_md_use, flush,
           grf_rs, grf_rt, e_res, m_res, w_res,
    input  stall, d_rs_val, d_rt_val, e_rs_sel, e_rt_sel, m_rt_sel, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wr, d_rd, d_tnew, d_md_start, d_md_div, d_md_use, flush,
           grf_rs, grf_rt, e_res, m_res, w_res,
    output stall, d_rs_val, d_rt_val, e_rs_sel, e_rt_sel, m_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for a five-stage pipeline: tracks E/M/W destination
// slots with Tnew countdowns, plus a mult/div busy counter.
module hazard_scoreboard #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic                clk,
  input logic                reset_n,
  hazard_scoreboard_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  // E slot
  logic          e_wr_reg;
  logic [AW-1:0] e_rd_reg;
  logic [AW-1:0] e_rs_reg;
  logic [AW-1:0] e_rt_reg;
  logic [TW-1:0] e_tnew_reg;
  // M slot
  logic          m_wr_reg;
  logic [AW-1:0] m_rd_reg;
  logic [AW-1:0] m_rt_reg;
  logic [TW-1:0] m_tnew_reg;
  // W slot
  logic          w_wr_reg;
  logic [AW-1:0] w_rd_reg;

  logic [CW-1:0] md_cnt_reg;

  // D fields with unused operands squashed to zero so they never match.
  logic [AW-1:0] d_rs_f;
  logic [AW-1:0] d_rt_f;
  logic [AW-1:0] d_rd_f;
  logic [TW-1:0] d_tnew_f;
  logic [TW-1:0] m_tnew_next;
  logic          md_busy;
  logic          md_stall;
  logic          advance;
  logic          stall;

  assign d_rs_f   = bus.d_use_rs ? bus.d_rs   : '0;
  assign d_rt_f   = bus.d_use_rt ? bus.d_rt   : '0;
  assign d_rd_f   = bus.d_wr     ? bus.d_rd   : '0;
  assign d_tnew_f = bus.d_wr     ? bus.d_tnew : '0;

  assign m_tnew_next = (e_tnew_reg == '0) ? '0 : e_tnew_reg - TW'(1);

  // Per-operand hazard detection and forwarding (index 0 = rs, 1 = rt).
  logic [AW-1:0] src      [2];
  logic          src_use  [2];
  logic [TW-1:0] src_tuse [2];
  logic [DW-1:0] src_grf  [2];
  logic [DW-1:0] src_val  [2];
  logic [AW-1:0] e_src    [2];
  logic [1:0]    e_sel    [2];
  logic [1:0]    src_stall;

  assign src[0]      = d_rs_f;
  assign src[1]      = d_rt_f;
  assign src_use[0]  = bus.d_use_rs;
  assign src_use[1]  = bus.d_use_rt;
  assign src_tuse[0] = bus.d_tuse_rs;
  assign src_tuse[1] = bus.d_tuse_rt;
  assign src_grf[0]  = bus.grf_rs;
  assign src_grf[1]  = bus.grf_rt;
  assign e_src[0]    = e_rs_reg;
  assign e_src[1]    = e_rt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic hit_e;
      logic hit_m;
      logic e_hit_m;
      logic e_hit_w;

      assign hit_e = (src[gi] != '0) && (src[gi] == e_rd_reg) && e_wr_reg;
      assign hit_m = (src[gi] != '0) && (src[gi] == m_rd_reg) && m_wr_reg;

      // A hazard stalls only if the value will not be ready by its use.
      assign src_stall[gi] = src_use[gi] &&
                             ((hit_e && (src_tuse[gi] < e_tnew_reg)) ||
                              (hit_m && (src_tuse[gi] < m_tnew_reg)));

      // W is not forwarded: the register file writes before it reads.
      assign src_val[gi] = hit_e ? bus.e_res :
                           hit_m ? bus.m_res : src_grf[gi];

      assign e_hit_m = (e_src[gi] != '0) && (e_src[gi] == m_rd_reg) && m_wr_reg;
      assign e_hit_w = (e_src[gi] != '0) && (e_src[gi] == w_rd_reg) && w_wr_reg;
      assign e_sel[gi] = e_hit_m ? 2'd1 : (e_hit_w ? 2'd2 : 2'd0);
    end
  endgenerate

  assign md_busy  = (md_cnt_reg != '0);
  assign md_stall = bus.d_md_use && md_busy;
  assign stall    = (|src_stall) || md_stall;
  assign advance  = !stall && !bus.flush;

  assign bus.stall    = stall;
  assign bus.md_busy  = md_busy;
  assign bus.d_rs_val = src_val[0];
  assign bus.d_rt_val = src_val[1];
  assign bus.e_rs_sel = e_sel[0];
  assign bus.e_rt_sel = e_sel[1];
  assign bus.m_rt_sel = (m_rt_reg != '0) && (m_rt_reg == w_rd_reg) && w_wr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_wr_reg   <= 1'b0;
      e_rd_reg   <= '0;
      e_rs_reg   <= '0;
      e_rt_reg   <= '0;
      e_tnew_reg <= '0;
      m_wr_reg   <= 1'b0;
      m_rd_reg   <= '0;
      m_rt_reg   <= '0;
      m_tnew_reg <= '0;
      w_wr_reg   <= 1'b0;
      w_rd_reg   <= '0;
      md_cnt_reg <= '0;
    end else begin
      w_wr_reg   <= m_wr_reg;
      w_rd_reg   <= m_rd_reg;
      m_wr_reg   <= e_wr_reg;
      m_rd_reg   <= e_rd_reg;
      m_rt_reg   <= e_rt_reg;
      m_tnew_reg <= m_tnew_next;
      if (advance) begin
        e_wr_reg   <= bus.d_wr;
        e_rd_reg   <= d_rd_f;
        e_rs_reg   <= d_rs_f;
        e_rt_reg   <= d_rt_f;
        e_tnew_reg <= d_tnew_f;
      end else begin
        e_wr_reg   <= 1'b0;
        e_rd_reg   <= '0;
        e_rs_reg   <= '0;
        e_rt_reg   <= '0;
        e_tnew_reg <= '0;
      end
      // The counter only loads when the mult/div really leaves D.
      if (advance && bus.d_md_start) begin
        md_cnt_reg <= bus.d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (md_cnt_reg != '0) begin
        md_cnt_reg <= md_cnt_reg - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step pushes its expected outputs
// to a queue, which is popped and compared on the following falling edge.
module tb_hazard_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  hazard_scoreboard_if #(.DW(DW), .AW(AW), .TW(TW)) bus ();

  hazard_scoreboard #(
    .DW(DW), .AW(AW), .TW(TW),
    .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] stall;
    logic [31:0] busy;
    logic [31:0] ers;
    logic [31:0] ert;
    logic [31:0] mrt;
    logic [31:0] rsv;
    logic [31:0] rtv;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", tag, what, obs, expv);
    end
  endtask

  task automatic d_set(input int rs, input int use_rs, input int tuse_rs,
                       input int rt, input int use_rt, input int tuse_rt,
                       input int wr, input int rd, input int tnew,
                       input int md_start, input int md_div, input int md_use);
    bus.d_rs       = AW'(rs);
    bus.d_use_rs   = 1'(use_rs);
    bus.d_tuse_rs  = TW'(tuse_rs);
    bus.d_rt       = AW'(rt);
    bus.d_use_rt   = 1'(use_rt);
    bus.d_tuse_rt  = TW'(tuse_rt);
    bus.d_wr       = 1'(wr);
    bus.d_rd       = AW'(rd);
    bus.d_tnew     = TW'(tnew);
    bus.d_md_start = 1'(md_start);
    bus.d_md_div   = 1'(md_div);
    bus.d_md_use   = 1'(md_use);
  endtask

  task automatic d_nop();
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // src codes: 0 register file, 1 e_res, 2 m_res
  task automatic step(input string tag, input int stall, input int busy,
                      input int ers, input int ert, input int mrt,
                      input int rs_src, input int rt_src);
    exp_t x;
    exp_t got;
    bus.grf_rs = $urandom;
    bus.grf_rt = $urandom;
    bus.e_res  = $urandom;
    bus.m_res  = $urandom;
    bus.w_res  = $urandom;
    x.tag   = tag;
    x.stall = 32'(stall);
    x.busy  = 32'(busy);
    x.ers   = 32'(ers);
    x.ert   = 32'(ert);
    x.mrt   = 32'(mrt);
    x.rsv   = (rs_src == 1) ? bus.e_res : (rs_src == 2) ? bus.m_res : bus.grf_rs;
    x.rtv   = (rt_src == 1) ? bus.e_res : (rt_src == 2) ? bus.m_res : bus.grf_rt;
    exp_q.push_back(x);
    @(negedge clk);
    got = exp_q.pop_front();
    chk(got.tag, "stall",    32'(bus.stall),    got.stall);
    chk(got.tag, "md_busy",  32'(bus.md_busy),  got.busy);
    chk(got.tag, "e_rs_sel", 32'(bus.e_rs_sel), got.ers);
    chk(got.tag, "e_rt_sel", 32'(bus.e_rt_sel), got.ert);
    chk(got.tag, "m_rt_sel", 32'(bus.m_rt_sel), got.mrt);
    chk(got.tag, "d_rs_val", bus.d_rs_val,      got.rsv);
    chk(got.tag, "d_rt_val", bus.d_rt_val,      got.rtv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.flush = 1'b0;
    d_nop();
    @(posedge clk);
    #1;
    step("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step("rst_rel", 0, 0, 0, 0, 0, 0, 0);

    // load-use: lw $3 (tnew 2), then beq on $3 (tuse 0)
    d_set(1, 1, 1, 0, 0, 0, 1, 3, 2, 0, 0, 0);
    step("lw", 0, 0, 0, 0, 0, 0, 0);
    d_set(3, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_stall1", 1, 0, 0, 0, 0, 1, 0);
    step("lu_stall2", 1, 0, 0, 0, 0, 2, 0);
    step("lu_go",     0, 0, 0, 0, 0, 0, 0);

    // ALU producer then consumer: E forward, then M select
    d_set(1, 1, 1, 2, 1, 1, 1, 5, 1, 0, 0, 0);
    step("addu_p", 0, 0, 0, 0, 0, 0, 0);
    d_set(5, 1, 1, 7, 1, 1, 1, 6, 1, 0, 0, 0);
    step("fwd_e", 0, 0, 0, 0, 0, 1, 0);
    d_nop();
    step("sel_m", 0, 0, 1, 0, 0, 0, 0);

    // same with one nop between: M forward in D, then W select in E
    d_set(1, 1, 1, 2, 1, 1, 1, 5, 1, 0, 0, 0);
    step("addu_p2", 0, 0, 0, 0, 0, 0, 0);
    d_nop();
    step("nop_gap", 0, 0, 0, 0, 0, 0, 0);
    d_set(5, 1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
    step("fwd_m", 0, 0, 0, 0, 0, 2, 2);
    d_nop();
    step("sel_w", 0, 0, 2, 2, 0, 0, 0);

    // store data forwarded from W into M
    d_set(1, 1, 1, 2, 1, 1, 1, 8, 1, 0, 0, 0);
    step("st_p", 0, 0, 0, 0, 0, 0, 0);
    d_set(9, 1, 1, 8, 1, 2, 0, 0, 0, 0, 0, 0);
    step("st_d", 0, 0, 0, 0, 0, 0, 1);
    d_nop();
    step("st_e",    0, 0, 0, 1, 0, 0, 0);
    step("st_m",    0, 0, 0, 0, 1, 0, 0);
    step("st_done", 0, 0, 0, 0, 0, 0, 0);

    // writes to $0 never stall or forward
    for (int t = 0; t < 4; t++) begin
      d_set(1, 1, 1, 2, 1, 1, 1, 0, t, 0, 0, 0);
      step("z_prod", 0, 0, 0, 0, 0, 0, 0);
      d_set(0, 1, 0, 0, 1, 0, 1, 0, t, 0, 0, 0);
      step("z_cons", 0, 0, 0, 0, 0, 0, 0);
    end
    d_nop();
    step("z_nop1", 0, 0, 0, 0, 0, 0, 0);
    step("z_nop2", 0, 0, 0, 0, 0, 0, 0);

    // flushed producer leaves no hazard; flushed div does not load counter
    d_set(1, 1, 1, 2, 1, 1, 1, 11, 1, 0, 0, 0);
    bus.flush = 1'b1;
    step("fl_prod", 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    d_set(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("fl_cons", 0, 0, 0, 0, 0, 0, 0);
    d_set(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 1);
    bus.flush = 1'b1;
    step("fl_div", 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    d_nop();
    step("fl_idle", 0, 0, 0, 0, 0, 0, 0);

    // div then mflo: stalled exactly DIV_CYCLES cycles
    d_set(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 1);
    step("div_iss", 0, 0, 0, 0, 0, 0, 0);
    d_set(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < DIV_CYCLES; i++) step("div_stall", 1, 1, 0, 0, 0, 0, 0);
    step("div_go", 0, 0, 0, 0, 0, 0, 0);
    d_nop();
    step("md_nop", 0, 0, 0, 0, 0, 0, 0);

    // back-to-back mult, then mflo: MULT_CYCLES stall each
    d_set(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
    step("mul_iss", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MULT_CYCLES; i++) step("mul_b2b", 1, 1, 0, 0, 0, 0, 0);
    step("mul_iss2", 0, 0, 0, 0, 0, 0, 0);
    d_set(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < MULT_CYCLES; i++) step("mul_stall", 1, 1, 0, 0, 0, 0, 0);
    step("mul_go", 0, 0, 0, 0, 0, 0, 0);

    // reset mid-divide clears the counter at once
    d_set(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 1);
    step("div2_iss", 0, 0, 0, 0, 0, 0, 0);
    d_nop();
    step("div2_a", 0, 1, 0, 0, 0, 0, 0);
    step("div2_b", 0, 1, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    step("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    d_set(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1);
    step("after_rst", 0, 0, 0, 0, 0, 0, 0);
    d_nop();
    step("final", 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
